colour_stream_ctrl: RTL and testbench
=====================================

# colour_stream_ctrl

Frame sequencer and flow controller for the `colour_app` phase/magnitude-to-RGB pipeline. It accepts one (phase, log_mag) sample per pixel over a valid/ready stream and drives `colour_app`'s advance enable (`ready`). It tracks which pipeline slots hold real samples and presents RGB pixels downstream with backpressure, raster coordinates and frame markers. It sits between the spectrum/bin buffer and the video framebuffer writer.

## Interface
- `H_PIXELS`, default 640: pixels per line.
- `V_LINES`, default 480: lines per frame.
- `clk`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a frame when idle.
- `abort`  in  1  single-cycle pulse; discards the frame in flight.
- `busy`  out  1  high while a frame is running or draining.
- `done`  out  1  one-cycle pulse when the last pixel is accepted downstream.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  input sample accepted when `s_valid && s_ready`.
- `s_phase`  in  16  signed phase.
- `s_log_mag`  in  8  brightness.
- `m_valid`  out  1  output pixel valid.
- `m_ready`  in  1  downstream accepts the pixel.
- `m_red`, `m_green`, `m_blue`  out  8 each  pixel colour.
- `m_x`  out  $clog2(H_PIXELS)  column of the current output pixel.
- `m_y`  out  $clog2(V_LINES)  row of the current output pixel.
- `m_sof`  out  1  first pixel of the frame (x=0, y=0).
- `m_eol`  out  1  last pixel of a line.
- `m_eof`  out  1  last pixel of the frame.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE → RUN:** on `start`. Input count and output x/y are cleared.
- **RUN → DRAIN:** on acceptance of input number H_PIXELS*V_LINES.
- **DRAIN → IDLE:** on downstream acceptance of the `m_eof` pixel; `done` pulses in that same transition cycle.
- **`start` while busy:** ignored.
- **`abort`:** takes effect in any state. Next state is IDLE, valid tags v[2:0] are cleared, `done` is not pulsed. `abort` has priority over `start` and over every other transition in the same cycle.
- **Advance:** `adv = !v[2] || m_ready`. `adv` drives `colour_app.ready`, so the whole pipeline moves only on `adv`.
- **`s_ready`:** equals `(state==RUN) && adv && (in_cnt < H_PIXELS*V_LINES)`.
- **Valid tags:** on each `adv` edge, `v[0] <= s_valid && s_ready`, `v[1] <= v[0]`, `v[2] <= v[1]`. When nothing is accepted, a bubble (`v[0]=0`) is inserted and the data is don't-care.
- **`m_valid`:** equals `v[2]`. The RGB outputs come directly from the `colour_app` output registers.
- **Coordinates:** x/y advance on `m_valid && m_ready`. x wraps at H_PIXELS-1 to 0 and increments y. `m_sof`, `m_eol` and `m_eof` are decoded combinationally from x/y and are qualified by `m_valid`.
- **Data hold:** while `m_valid && !m_ready`, `adv=0`, so RGB and coordinates stay frozen.
- **`colour_app` reset:** its synchronous reset is driven from `resetn`. Its data registers are not otherwise reset; correctness relies only on the tags.

## Timing
- **Reset values:** state=IDLE, v=000, `busy`=0, `done`=0, `s_ready`=0, `m_valid`=0, `m_x`=0, `m_y`=0, flags=0. `m_red`/`m_green`/`m_blue` read 0 after a reset of at least one clock edge.
- **Latency:** 3 advancing edges. With `m_ready` held high, a sample accepted at edge N appears with `m_valid=1` after edge N+3.
- **Throughput:** one pixel per cycle with `m_ready` held high.
- **Backpressure:** `s_ready` falls in the same cycle `m_ready` falls while `m_valid=1` (combinational path `m_ready` → `s_ready`). No data is lost or duplicated.
- **Pipeline emptying:** a stall with v[2]=0 does not occur, because bubbles collapse: the pipeline advances whenever the output slot is empty.
- **`busy`:** high from the cycle after `start` until the cycle after `done`.
- **Back-to-back frames:** a `start` in the cycle after `done` is accepted.
- **Reset mid-frame:** everything returns to reset values immediately, asynchronously.

## Structure
- **Shared package (`colour_pkg`):** the state enum {IDLE, RUN, DRAIN}, `PIPE_LAT = 3`, and the RGB pixel width constant (8).
- **Sub-module:** one instance of `colour_app` as the datapath. The FSM, tags and counters stay in this module; no further sub-modules.

## Test plan
- **Streaming frame:** H=4, V=2, `m_ready` held at 1, 8 samples streamed back-to-back after `start`. Required: 8 pixels out, first at cycle +3. `m_sof` on pixel 0, `m_eol` on x=3 (pixels 3 and 7), `m_eof` on pixel 7. `done` pulses once, then `busy`=0.
- **Hue check:** phase=0x8000 with log_mag=0xFF gives RGB (0xFE,0x00,0x00). phase=0x2B00−0x8000 gives green≈0xFE. log_mag=0 gives (0,0,0).
- **Random backpressure:** `m_ready` random at 50%, `s_valid` random. Required: output pixel sequence equals the input order with no drops or duplicates; RGB/x/y stable while stalled.
- **Input count limit:** `s_valid` held high beyond 8 samples. Required: `s_ready`=0 after the 8th acceptance; DRAIN finishes the 3 in-flight pixels.
- **Abort:** `abort` pulsed after 5 inputs with pixels in flight. Required: next cycle `m_valid`=0, state IDLE, no `done`. A fresh `start` then produces a full clean frame starting at x=0, y=0.
- **Async reset:** `resetn` asserted mid-DRAIN. Required: all outputs go to reset values without a clock edge.

Source files
------------

// File: rtl/colour_pkg.sv
// Shared types and helpers for the colour_app pipeline and its stream controller.
package colour_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int PIPE_LAT = 3;
    localparam int RGB_W    = 8;

    // Phase is offset by half a turn so phase 0x8000 lands on pure red; result is {sector[2:0], frac[7:0]}.
    function automatic logic [10:0] hue_split(input logic [15:0] phase);
        return 11'(({3'd0, phase ^ 16'h8000} * 19'd6) >> 8);
    endfunction

    function automatic logic [RGB_W-1:0] scale_mag(input logic [7:0] c, input logic [7:0] m);
        return 8'(({8'd0, c} * {8'd0, m}) >> 8);
    endfunction

endpackage

// File: rtl/colour_app.sv
// Three-stage phase/magnitude to RGB datapath; every stage moves only when ready is high.
module colour_app
    import colour_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             ready,
    input  logic [15:0]      phase,
    input  logic [7:0]       log_mag,
    output logic [RGB_W-1:0] red,
    output logic [RGB_W-1:0] green,
    output logic [RGB_W-1:0] blue
);

    logic [10:0] hs_s;
    logic [2:0]  sector_r;
    logic [7:0]  frac_r;
    logic [7:0]  mag1_r;
    logic [7:0]  rise_s;
    logic [7:0]  fall_s;
    logic [7:0]  cr_s;
    logic [7:0]  cg_s;
    logic [7:0]  cb_s;
    logic [7:0]  cr_r;
    logic [7:0]  cg_r;
    logic [7:0]  cb_r;
    logic [7:0]  mag2_r;

    assign hs_s = hue_split(phase);

    // Stage 1: hue sector and position within the sector.
    always_ff @(posedge clk) begin
        if (srst) begin
            sector_r <= 3'd0;
            frac_r   <= 8'd0;
            mag1_r   <= 8'd0;
        end else if (ready) begin
            sector_r <= hs_s[10:8];
            frac_r   <= hs_s[7:0];
            mag1_r   <= log_mag;
        end
    end

    // Full-brightness colour wheel: one channel ramps per sector.
    always_comb begin
        rise_s = frac_r;
        fall_s = 8'hFF - frac_r;
        cr_s   = 8'd0;
        cg_s   = 8'd0;
        cb_s   = 8'd0;
        case (sector_r)
            3'd0: begin cr_s = 8'hFF;  cg_s = rise_s; end
            3'd1: begin cr_s = fall_s; cg_s = 8'hFF;  end
            3'd2: begin cg_s = 8'hFF;  cb_s = rise_s; end
            3'd3: begin cg_s = fall_s; cb_s = 8'hFF;  end
            3'd4: begin cr_s = rise_s; cb_s = 8'hFF;  end
            3'd5: begin cr_s = 8'hFF;  cb_s = fall_s; end
            default: begin cr_s = 8'd0; cg_s = 8'd0; cb_s = 8'd0; end
        endcase
    end

    // Stage 2: unscaled channel values.
    always_ff @(posedge clk) begin
        if (srst) begin
            cr_r   <= 8'd0;
            cg_r   <= 8'd0;
            cb_r   <= 8'd0;
            mag2_r <= 8'd0;
        end else if (ready) begin
            cr_r   <= cr_s;
            cg_r   <= cg_s;
            cb_r   <= cb_s;
            mag2_r <= mag1_r;
        end
    end

    // Stage 3: brightness scaling into the output registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            red   <= 8'd0;
            green <= 8'd0;
            blue  <= 8'd0;
        end else if (ready) begin
            red   <= scale_mag(cr_r, mag2_r);
            green <= scale_mag(cg_r, mag2_r);
            blue  <= scale_mag(cb_r, mag2_r);
        end
    end

endmodule

// File: rtl/colour_stream_ctrl.sv
// Frame sequencer and flow controller around colour_app: valid tags, backpressure, raster coordinates.
module colour_stream_ctrl
    import colour_pkg::*;
#(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [15:0]                   s_phase,
    input  logic [7:0]                    s_log_mag,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [RGB_W-1:0]              m_red,
    output logic [RGB_W-1:0]              m_green,
    output logic [RGB_W-1:0]              m_blue,
    output logic [$clog2(H_PIXELS)-1:0]   m_x,
    output logic [$clog2(V_LINES)-1:0]    m_y,
    output logic                          m_sof,
    output logic                          m_eol,
    output logic                          m_eof
);

    localparam int N_PIX = H_PIXELS * V_LINES;
    localparam int CW    = $clog2(N_PIX + 1);
    localparam int XW    = $clog2(H_PIXELS);
    localparam int YW    = $clog2(V_LINES);
    localparam logic [CW-1:0] N_PIX_C  = CW'(N_PIX);
    localparam logic [CW-1:0] N_LAST_C = CW'(N_PIX - 1);
    localparam logic [XW-1:0] X_LAST_C = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST_C = YW'(V_LINES - 1);

    state_t              state_r;
    logic [PIPE_LAT-1:0] v_r;
    logic [CW-1:0]       in_cnt_r;
    logic [XW-1:0]       x_r;
    logic [YW-1:0]       y_r;
    logic                adv_s;
    logic                accept_s;
    logic                out_fire_s;
    logic                last_x_s;
    logic                last_y_s;
    logic                srst_s;

    // The pipeline only stalls when a real pixel is waiting at the output; bubbles collapse.
    assign adv_s      = !v_r[PIPE_LAT-1] || m_ready;
    assign s_ready    = (state_r == RUN) && adv_s && (in_cnt_r < N_PIX_C);
    assign accept_s   = s_valid && s_ready;
    assign out_fire_s = v_r[PIPE_LAT-1] && m_ready;
    assign last_x_s   = (x_r == X_LAST_C);
    assign last_y_s   = (y_r == Y_LAST_C);

    assign busy    = (state_r != IDLE);
    assign done    = (state_r == DRAIN) && out_fire_s && last_x_s && last_y_s && !abort;
    assign m_valid = v_r[PIPE_LAT-1];
    assign m_x     = x_r;
    assign m_y     = y_r;
    assign m_sof   = m_valid && (x_r == '0) && (y_r == '0);
    assign m_eol   = m_valid && last_x_s;
    assign m_eof   = m_valid && last_x_s && last_y_s;
    assign srst_s  = !resetn;

    // Frame state and pipeline valid tags; abort overrides everything else.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            v_r     <= '0;
        end else if (abort) begin
            state_r <= IDLE;
            v_r     <= '0;
        end else begin
            case (state_r)
                IDLE:    if (start) state_r <= RUN;
                RUN:     if (accept_s && (in_cnt_r == N_LAST_C)) state_r <= DRAIN;
                DRAIN:   if (done) state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
            if (adv_s) begin
                v_r <= {v_r[PIPE_LAT-2:0], accept_s};
            end
        end
    end

    // Input count and output raster position, cleared when a frame starts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_cnt_r <= '0;
            x_r      <= '0;
            y_r      <= '0;
        end else if ((state_r == IDLE) && start && !abort) begin
            in_cnt_r <= '0;
            x_r      <= '0;
            y_r      <= '0;
        end else begin
            if (accept_s) begin
                in_cnt_r <= in_cnt_r + CW'(1);
            end
            if (out_fire_s) begin
                if (last_x_s) begin
                    x_r <= '0;
                    y_r <= last_y_s ? '0 : y_r + YW'(1);
                end else begin
                    x_r <= x_r + XW'(1);
                end
            end
        end
    end

    colour_app u_colour_app (
        .clk     (clk),
        .srst    (srst_s),
        .ready   (adv_s),
        .phase   (s_phase),
        .log_mag (s_log_mag),
        .red     (m_red),
        .green   (m_green),
        .blue    (m_blue)
    );

endmodule

// File: tb/tb_colour_stream_ctrl.sv
// Directed bench for colour_stream_ctrl on a 4x2 frame with hand-computed RGB values.
module tb_colour_stream_ctrl;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int NP = H * V;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_phase = 16'd0;
    logic [7:0]  s_log_mag = 8'd0;
    logic        m_ready = 1'b0;
    logic        busy, done, s_ready, m_valid, m_sof, m_eol, m_eof;
    logic [7:0]  m_red, m_green, m_blue;
    logic [1:0]  m_x;
    logic [0:0]  m_y;

    int tests_run = 0;
    int tests_failed = 0;

    // Red at -pi, yellow edge, black, cyan at 0, then red ramps with brightness 255*m>>8.
    logic [15:0] ph_tab [NP] = '{16'h8000, 16'hAB00, 16'h1234, 16'h0000,
                                 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    logic [7:0]  mg_tab [NP] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40};
    logic [23:0] rgb_tab [NP] = '{24'hFE0000, 24'hFCFE00, 24'h000000, 24'h00FEFE,
                                  24'h0F0000, 24'h1F0000, 24'h2F0000, 24'h3F0000};

    always #5 clk = ~clk;

    colour_stream_ctrl #(.H_PIXELS(H), .V_LINES(V)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_phase   (s_phase),
        .s_log_mag (s_log_mag),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_red     (m_red),
        .m_green   (m_green),
        .m_blue    (m_blue),
        .m_x       (m_x),
        .m_y       (m_y),
        .m_sof     (m_sof),
        .m_eol     (m_eol),
        .m_eof     (m_eof)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_xy"},      32'({m_x, m_y}), 32'd0);
        check({tag, "_flags"},   32'({m_sof, m_eol, m_eof}), 32'd0);
    endtask

    task automatic run_frame(input string nm, input bit rand_io, input int abort_at);
        int  n_in = 0;
        int  n_out = 0;
        int  n_done = 0;
        int  cyc = 0;
        int  acc0 = 0;
        bit  stalled = 1'b0;
        bit  lim_chk = 1'b0;
        bit  aborted = 1'b0;
        logic [23:0] held_rgb = 24'd0;
        logic [2:0]  held_xy = 3'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({nm, "_busy_after_start"}, 32'(busy), 32'd1);
        while (n_out < NP && cyc < 400 && !aborted) begin
            if (abort_at > 0 && n_in == abort_at) begin
                abort = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
                #3;
                check({nm, "_abort_no_done"}, 32'(done), 32'd0);
                @(posedge clk); #1;
                abort = 1'b0;
                check({nm, "_abort_m_valid"}, 32'(m_valid), 32'd0);
                check({nm, "_abort_busy"},    32'(busy),    32'd0);
                check({nm, "_abort_s_ready"}, 32'(s_ready), 32'd0);
                aborted = 1'b1;
            end else begin
                m_ready   = rand_io ? 1'($urandom_range(0, 1)) : 1'b1;
                s_valid   = rand_io ? 1'($urandom_range(0, 1)) : 1'b1;
                start     = rand_io && (cyc == 2);
                s_phase   = ph_tab[n_in % NP];
                s_log_mag = mg_tab[n_in % NP];
                #3;
                if (stalled) begin
                    check({nm, "_hold_rgb"}, 32'({m_red, m_green, m_blue}), 32'(held_rgb));
                    check({nm, "_hold_xy"},  32'({m_x, m_y}), 32'(held_xy));
                end
                if (n_in >= NP && (!lim_chk || s_ready)) begin
                    check({nm, "_in_limit"}, 32'(s_ready), 32'd0);
                    lim_chk = 1'b1;
                end
                check({nm, "_done"}, 32'(done), 32'(m_valid && m_ready && (n_out == NP - 1)));
                if (done) n_done++;
                if (m_valid && m_ready) begin
                    if (n_out == 0 && !rand_io) begin
                        check({nm, "_latency"}, 32'(cyc - acc0), 32'd3);
                    end
                    check({nm, "_rgb"},   32'({m_red, m_green, m_blue}), 32'(rgb_tab[n_out]));
                    check({nm, "_xy"},    32'({m_x, m_y}), 32'({2'(n_out % H), 1'(n_out / H)}));
                    check({nm, "_flags"}, 32'({m_sof, m_eol, m_eof}),
                          32'({n_out == 0, (n_out % H) == H - 1, n_out == NP - 1}));
                    n_out++;
                end
                stalled = m_valid && !m_ready;
                if (stalled) begin
                    held_rgb = {m_red, m_green, m_blue};
                    held_xy  = {m_x, m_y};
                end
                if (s_valid && s_ready) begin
                    if (n_in == 0) acc0 = cyc;
                    n_in++;
                end
                @(posedge clk); #1;
                start = 1'b0;
                cyc++;
            end
        end
        s_valid = 1'b0;
        if (abort_at == 0) begin
            check({nm, "_pixels"},     32'(n_out),   32'(NP));
            check({nm, "_done_count"}, 32'(n_done),  32'd1);
            check({nm, "_busy_end"},   32'(busy),    32'd0);
            check({nm, "_valid_end"},  32'(m_valid), 32'd0);
        end else begin
            check({nm, "_aborted"}, 32'(aborted), 32'd1);
        end
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_rgb", 32'({m_red, m_green, m_blue}), 32'd0);
        #4 resetn = 1'b1;
        @(posedge clk); #1;

        run_frame("stream", 1'b0, 0);
        run_frame("backpressure", 1'b1, 0);
        run_frame("abort", 1'b0, 5);
        run_frame("post_abort", 1'b0, 0);

        // Asynchronous reset while a pixel is stalled in DRAIN.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; m_ready = 1'b1; s_valid = 1'b1; n = 0;
        for (int c = 0; c < 50 && n < NP; c++) begin
            s_phase = ph_tab[n]; s_log_mag = mg_tab[n];
            #3;
            if (s_valid && s_ready) n++;
            @(posedge clk); #1;
        end
        m_ready = 1'b0; s_valid = 1'b0;
        @(posedge clk); #1;
        check("drain_busy",  32'(busy),    32'd1);
        check("drain_valid", 32'(m_valid), 32'd1);
        check("drain_xy",    32'({m_x, m_y}), 32'({2'd1, 1'b1}));
        #1 resetn = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check("async_reset_rgb", 32'({m_red, m_green, m_blue}), 32'd0);
        #4 resetn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
